// File: rtl/rng_pkg.sv
// Shared constants for the xorshift32 card generator.
// No logic here: shift amounts, deck geometry and the post-reset seed.
package rng_pkg;

    localparam int SHL_A = 13;
    localparam int SHR_B = 17;
    localparam int SHL_C = 5;

    localparam int DECK_SIZE = 52;
    localparam int NUM_RANKS = 13;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

endpackage

// File: rtl/rng_card_map.sv
// Maps a 32-bit value to deck index (x mod 52) and rank ((index mod 13) + 1).
// Latency: combinational; backpressure: none.
module rng_card_map
    import rng_pkg::*;
(
    input  logic [31:0] x,
    output logic [5:0]  index,
    output logic [3:0]  rank
);

    // x mod 52 == 4 * ((x >> 2) mod 13) + x[1:0]; the mod-13 uses 2^12 == 1 and
    // 2^4 == 3 (mod 13) to fold the operand down to a five-bit value.
    function automatic logic [3:0] fold_mod13(input logic [29:0] q);
        logic [13:0] s1;
        logic [12:0] s2;
        logic [9:0]  s3;
        logic [7:0]  s4;
        logic [5:0]  s5;
        logic [4:0]  s6;
        s1 = 14'(q[11:0]) + 14'(q[23:12]) + 14'(q[29:24]);
        s2 = 13'(s1[11:0]) + 13'(s1[13:12]);
        s3 = 10'(s2[12:4]) * 10'd3 + 10'(s2[3:0]);
        s4 = 8'(s3[9:4]) * 8'd3 + 8'(s3[3:0]);
        s5 = 6'(s4[7:4]) * 6'd3 + 6'(s4[3:0]);
        s6 = 5'(s5[5:4]) * 5'd3 + 5'(s5[3:0]);
        return (s6 >= 5'(NUM_RANKS)) ? 4'(s6 - 5'(NUM_RANKS)) : s6[3:0];
    endfunction

    logic [3:0] quarter_mod;
    logic [3:0] rem;

    always_comb begin
        quarter_mod = fold_mod13(x[31:2]);
        index       = {quarter_mod, x[1:0]};

        // index < 52, so at most three subtractions of 13
        if (index >= 6'(3 * NUM_RANKS)) begin
            rem = 4'(index - 6'(3 * NUM_RANKS));
        end else if (index >= 6'(2 * NUM_RANKS)) begin
            rem = 4'(index - 6'(2 * NUM_RANKS));
        end else if (index >= 6'(NUM_RANKS)) begin
            rem = 4'(index - 6'(NUM_RANKS));
        end else begin
            rem = index[3:0];
        end
        rank = rem + 4'd1;
    end

endmodule

// File: rtl/rng_xorshift32_step.sv
// One xorshift32 step, y = f(x); maps 0 to 0.
// Latency: combinational; backpressure: none.
module rng_xorshift32_step
    import rng_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [31:0] t0;
    logic [31:0] t1;

    always_comb begin
        t0 = x ^ (x << SHL_A);
        t1 = t0 ^ (t0 >> SHR_B);
        y  = t1 ^ (t1 << SHL_C);
    end

endmodule

// File: rtl/rng.sv
// Seedable xorshift32 generator with card mapping plus a free combinational step.
// Latency: next/next_rank 0 cycles, state 1 cycle; backpressure: none, every cycle accepts a command.
module rng #(
    parameter logic [31:0] DEFAULT_SEED = rng_pkg::DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] current,
    output logic [31:0] next,
    output logic [3:0]  next_rank,
    input  logic        seed_load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state,
    output logic [5:0]  card_index,
    output logic [3:0]  card_rank
);

    import rng_pkg::*;

    logic [31:0] state_q;
    logic [31:0] state_step;
    logic [5:0]  next_index_unused;

    rng_xorshift32_step u_next_step (
        .x (current),
        .y (next)
    );

    rng_xorshift32_step u_state_step (
        .x (state_q),
        .y (state_step)
    );

    rng_card_map u_next_map (
        .x     (next),
        .index (next_index_unused),
        .rank  (next_rank)
    );

    rng_card_map u_state_map (
        .x     (state_q),
        .index (card_index),
        .rank  (card_rank)
    );

    // A zero seed would lock xorshift at 0 forever, so it is replaced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DEFAULT_SEED;
        end else if (seed_load) begin
            state_q <= (seed == 32'd0) ? DEFAULT_SEED : seed;
        end else if (step) begin
            state_q <= state_step;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_rng.sv
// Self-checking bench for rng: directed spec points plus a randomized run
// against an arithmetic reference model.
module tb_rng;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] current;
    logic [31:0] next;
    logic [3:0]  next_rank;
    logic        seed_load;
    logic [31:0] seed;
    logic        step;
    logic [31:0] state;
    logic [5:0]  card_index;
    logic [3:0]  card_rank;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_state;

    always #5 clk = ~clk;

    rng dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .current    (current),
        .next       (next),
        .next_rank  (next_rank),
        .seed_load  (seed_load),
        .seed       (seed),
        .step       (step),
        .state      (state),
        .card_index (card_index),
        .card_rank  (card_rank)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Shifts written as multiply/divide by powers of two, truncated to 32 bits.
    function automatic logic [31:0] ref_xs(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x * 32'd8192);
        t = t ^ (t / 32'd131072);
        return t ^ (t * 32'd32);
    endfunction

    function automatic logic [31:0] ref_index(input logic [31:0] v);
        return v % 32'd52;
    endfunction

    function automatic logic [31:0] ref_rank(input logic [31:0] v);
        return ((v % 32'd52) % 32'd13) + 32'd1;
    endfunction

    // Inverse of ref_xs by fixed-point iteration of each xor-shift stage.
    function automatic logic [31:0] ref_inv(input logic [31:0] y);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        c = y;
        for (int i = 0; i < 32; i++) c = y ^ (c * 32'd32);
        b = c;
        for (int i = 0; i < 32; i++) b = c ^ (b / 32'd131072);
        a = b;
        for (int i = 0; i < 32; i++) a = b ^ (a * 32'd8192);
        return a;
    endfunction

    task automatic tick();
        if (!rst_n)         model_state = 32'd1;
        else if (seed_load) model_state = (seed == 32'd0) ? 32'd1 : seed;
        else if (step)      model_state = ref_xs(model_state);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_state"}, state, model_state);
        check({tag, "_index"}, 32'(card_index), ref_index(model_state));
        check({tag, "_rank"},  32'(card_rank),  ref_rank(model_state));
    endtask

    logic [31:0] edge_val  [4] = '{32'd51, 32'd52, 32'd12, 32'd13};
    logic [31:0] edge_idx  [4] = '{32'd51, 32'd0,  32'd12, 32'd13};
    logic [31:0] edge_rank [4] = '{32'd13, 32'd1,  32'd13, 32'd1};

    initial begin
        rst_n = 1'b0; seed_load = 1'b0; step = 1'b0; seed = '0; current = '0;
        model_state = 32'd1;
        tick();
        tick();
        check("rst_state", state, 32'd1);
        check("rst_index", 32'(card_index), 32'd1);
        check("rst_rank",  32'(card_rank), 32'd2);
        rst_n = 1'b1;

        current = 32'd1; #1;
        check("chain1_next", next, 32'd270369);
        check("chain1_rank", 32'(next_rank), 32'd9);
        current = next; #1;
        check("chain2_next", next, 32'd67634689);
        check("chain2_rank", 32'(next_rank), 32'd6);

        current = 32'd0; #1;
        check("zero_next", next, 32'd0);
        check("zero_rank", 32'(next_rank), 32'd1);
        current = 32'hFFFF_FFFF; #1;
        check("ones_next", next, ref_xs(32'hFFFF_FFFF));
        check("ones_rank", 32'(next_rank), ref_rank(ref_xs(32'hFFFF_FFFF)));

        for (int i = 0; i < 4; i++) begin
            current = ref_inv(edge_val[i]); #1;
            check("edge_next", next, edge_val[i]);
            check("edge_next_rank", 32'(next_rank), edge_rank[i]);
        end

        step = 1'b1; tick(); step = 1'b0;
        check("step1_state", state, 32'd270369);
        check("step1_index", 32'(card_index), 32'd21);
        check("step1_rank",  32'(card_rank), 32'd9);
        step = 1'b1; tick(); step = 1'b0;
        check("step2_state", state, 32'd67634689);
        check("step2_index", 32'(card_index), 32'd5);
        check("step2_rank",  32'(card_rank), 32'd6);

        seed_load = 1'b1; seed = 32'd0; tick();
        check("seed0_state", state, 32'd1);
        step = 1'b1; seed = 32'd12345; tick();
        check("seed_step_state", state, 32'd12345);
        seed_load = 1'b0;

        tick();
        tick();
        check_state("run");
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("midrst_state", state, 32'd1);
        step = 1'b0;

        for (int i = 0; i < 4; i++) begin
            seed_load = 1'b1; seed = edge_val[i]; tick();
            check("edge_card_index", 32'(card_index), edge_idx[i]);
            check("edge_card_rank",  32'(card_rank),  edge_rank[i]);
        end
        seed_load = 1'b0;

        step = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            seed_load = ($urandom_range(31) == 0);
            seed      = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            current   = $urandom;
            #1;
            check("rnd_next", next, ref_xs(current));
            check("rnd_next_rank", 32'(next_rank), ref_rank(ref_xs(current)));
            tick();
            check_state("rnd");
            check("rnd_rank_range", 32'(card_rank >= 4'd1 && card_rank <= 4'd13), 32'd1);
            check("rnd_nonzero", 32'(state != 32'd0), 32'd1);
        end
        step = 1'b0; seed_load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
